// File: rtl/dsp_ctrl_pkg.sv
// Shared types and defaults for the DSP48A1 MAC sequencer.
// FSM state encoding and OPMODE constants.
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0] OPMODE_LOAD_DEF = 8'h01;
  localparam logic [7:0] OPMODE_ACC_DEF  = 8'h09;

endpackage

// File: rtl/dsp_token_pipe.sv
// Two-stage {vld,first} token pipe tracking operands
// through the slice M and P registers.
module dsp_token_pipe (
  input  logic clk,
  input  logic clr,
  input  logic vld_in,
  input  logic first_in,
  output logic vld1,
  output logic first1,
  output logic vld2,
  output logic first2
);

  always_ff @(posedge clk) begin
    if (clr) begin
      vld1   <= 1'b0;
      first1 <= 1'b0;
      vld2   <= 1'b0;
      first2 <= 1'b0;
    end else begin
      vld1   <= vld_in;
      first1 <= first_in;
      vld2   <= vld1;
      first2 <= first1;
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice through an N-term MAC job:
// command intake, operand handshake, per-stage CEs, OPMODE.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int         LEN_W       = 8,
  parameter logic [7:0] OPMODE_LOAD = OPMODE_LOAD_DEF,
  parameter logic [7:0] OPMODE_ACC  = OPMODE_ACC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_dsp,
  output logic [7:0]       opmode,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             rst_dsp_q;

  logic accept;
  logic cnt_last;
  logic kill;
  logic vld1;
  logic first1;
  logic vld2;
  logic first2;

  assign cmd_ready = (state_q == S_IDLE);
  assign op_ready  = (state_q == S_FEED);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign accept    = op_valid & op_ready;
  assign ce_ab     = accept;
  assign cnt_last  = (cnt_q == len_q - ONE);
  assign kill      = abort &
                     ((state_q == S_FEED) |
                      (state_q == S_DRAIN));

  // an accept in the abort cycle is dropped by the clear
  dsp_token_pipe u_pipe (
    .clk      (clk),
    .clr      (rst | kill),
    .vld_in   (accept),
    .first_in (accept & (cnt_q == '0)),
    .vld1     (vld1),
    .first1   (first1),
    .vld2     (vld2),
    .first2   (first2)
  );

  assign ce_m    = vld1;
  assign ce_p    = vld2;
  assign opmode  = first2 ? OPMODE_LOAD : OPMODE_ACC;
  assign rst_dsp = rst_dsp_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid)
          state_d = (cmd_len == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (kill)
          state_d = S_IDLE;
        else if (accept && cnt_last)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (kill)
          state_d = S_IDLE;
        else if (!vld1)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      rst_dsp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_dsp_q <= kill;
      if (state_q == S_IDLE && cmd_valid) begin
        len_q <= cmd_len;
        cnt_q <= '0;
      end else if (accept && !cnt_last) begin
        cnt_q <= cnt_q + ONE;
      end
    end
  end

endmodule
